// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and opcodes for the branch compare path
//
// Purpose: FSM state encoding, result flag bundle and the branch opcodes
// whose select logic consumes the Igual/Maior/Menor flags.
// Ports: none (package).
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic igual;
    logic maior;
    logic menor;
  } cmp_flags_t;

  localparam logic [5:0] OP_BLTZ = 6'd1;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_BLEZ = 6'd6;
  localparam logic [5:0] OP_BGTZ = 6'd7;

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned compare of one operand chunk
//
// Purpose: compares two CHUNK-bit slices as unsigned numbers. Inverting the
// top bit on both sides turns a two's-complement compare of the most
// significant chunk into an unsigned one.
// Ports:
//   a, b        in  CHUNK  operand slices
//   invert_msb  in  1      flip bit CHUNK-1 of both slices before comparing
//   eq, gt, lt  out 1      a == b, a > b, a < b
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] msb_mask;
  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  always_comb begin
    msb_mask           = '0;
    msb_mask[CHUNK-1]  = invert_msb;
  end

  assign a_x = a ^ msb_mask;
  assign b_x = b ^ msb_mask;

  assign eq = (a_x == b_x);
  assign gt = (a_x > b_x);
  assign lt = (a_x < b_x);

endmodule

// File: rtl/branch_cmp_seq.sv
// rtl/branch_cmp_seq.sv - multicycle chunked comparator feeding branch select
//
// Purpose: latches A/B/is_signed on an accepted start and compares the
// operands CHUNK bits per cycle from the MSB side, producing registered
// Igual/Maior/Menor flags that stay stable until the next result.
// Build option: BRANCH_CMP_EARLY_EXIT_EN - when defined, the compare stops at
// the first differing chunk; otherwise all NCHUNK chunks are always scanned
// so the branch latency is fixed.
// Ports:
//   clk                in  1      rising-edge clock
//   reset              in  1      asynchronous active-low reset
//   start              in  1      request strobe, honoured in IDLE or DONE
//   A, B               in  WIDTH  operands, captured on accepted start
//   is_signed          in  1      1 = two's-complement compare
//   busy               out 1      high while in CMP
//   done               out 1      one-cycle pulse when flags become valid
//   Igual/Maior/Menor  out 1      A == B / A > B / A < B
module branch_cmp_seq
  import branch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             Igual,
  output logic             Maior,
  output logic             Menor
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  cmp_state_t                   state_q;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q;
  logic [NCHUNK-1:0][CHUNK-1:0] b_q;
  logic                         signed_q;
  logic [IDXW-1:0]              idx_q;
  cmp_flags_t                   flags_q;
  logic                         busy_q;
  logic                         done_q;

`ifndef BRANCH_CMP_EARLY_EXIT_EN
  // Full-scan mode: remember the first (MSB-side) differing chunk's verdict.
  logic                         found_q;
  logic                         gt_seen_q;
`endif

  logic c_eq;
  logic c_gt;
  logic c_lt;

  chunk_cmp #(
    .CHUNK(CHUNK)
  ) u_chunk_cmp (
    .a          (a_q[idx_q]),
    .b          (b_q[idx_q]),
    .invert_msb (signed_q && (idx_q == LAST_IDX)),
    .eq         (c_eq),
    .gt         (c_gt),
    .lt         (c_lt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifndef BRANCH_CMP_EARLY_EXIT_EN
      found_q   <= 1'b0;
      gt_seen_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            signed_q <= is_signed;
            idx_q    <= LAST_IDX;
            busy_q   <= 1'b1;
            state_q  <= CMP;
`ifndef BRANCH_CMP_EARLY_EXIT_EN
            found_q  <= 1'b0;
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        CMP: begin
`ifdef BRANCH_CMP_EARLY_EXIT_EN
          if (!c_eq || (idx_q == '0)) begin
            flags_q <= '{igual: c_eq, maior: c_gt, menor: c_lt};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
`else
          if (idx_q == '0) begin
            // An earlier (more significant) difference outranks chunk 0.
            if (found_q) begin
              flags_q <= '{igual: 1'b0, maior: gt_seen_q, menor: !gt_seen_q};
            end else begin
              flags_q <= '{igual: c_eq, maior: c_gt, menor: c_lt};
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            if (!found_q && !c_eq) begin
              found_q   <= 1'b1;
              gt_seen_q <= c_gt;
            end
            idx_q <= idx_q - 1'b1;
          end
`endif
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Igual = flags_q.igual;
  assign Maior = flags_q.maior;
  assign Menor = flags_q.menor;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// tb/tb_branch_cmp_seq.sv - self-checking bench for branch_cmp_seq
module tb_branch_cmp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic        Igual;
  logic        Maior;
  logic        Menor;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [2:0]  flags;  // {Igual, Maior, Menor}
  } vec_t;

  typedef struct {
    logic [2:0] flags;
    int         done_cyc;
  } exp_t;

  vec_t       vecs[10];
  exp_t       sb[$];
  logic [2:0] last_flags = 3'b000;

  branch_cmp_seq #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .Igual     (Igual),
    .Maior     (Maior),
    .Menor     (Menor)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
    int first;
    first = 4;
    for (int i = 3; i >= 0; i--) begin
      if (a[i*8 +: 8] != b[i*8 +: 8]) begin
        first = 4 - i;
        break;
      end
    end
`ifndef BRANCH_CMP_EARLY_EXIT_EN
    first = 4;
`endif
    return first;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("flags", {29'd0, Igual, Maior, Menor}, {29'd0, e.flags});
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic do_cmp(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [2:0] ef, input int inj);
    int lat;
    int bcnt;
    bit seen;
    lat = exp_lat(a, b);
    @(negedge clk);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{ef, cyc + lat});
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("flags_held", {29'd0, Igual, Maior, Menor}, {29'd0, last_flags});
        A = ~a; B = ~b; is_signed = ~s;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      start = (inj != 0 && i == inj);
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_cycles", bcnt, lat);
    last_flags = ef;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    vecs[0] = '{32'h12345678, 32'h12345678, 1'b1, 3'b100};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b001};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 3'b010};
    vecs[3] = '{32'h00000101, 32'h00000100, 1'b0, 3'b010};
    vecs[4] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b001};
    vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b010};
    vecs[6] = '{32'h00000003, 32'h00000005, 1'b1, 3'b001};
    vecs[7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b001};
    vecs[8] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b010};
    vecs[9] = '{32'h00120000, 32'h00110000, 1'b0, 3'b010};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; is_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'd0, busy, done, Igual, Maior, Menor}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      do_cmp(vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].flags, 0);
    end

    // Start pulse in the middle of CMP must be ignored.
    do_cmp(32'h00000101, 32'h00000100, 1'b0, 3'b010, 2);

    // Back-to-back: start held high through DONE; operands change mid-CMP.
    @(negedge clk);
    A = 32'd7; B = 32'd7; is_signed = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{3'b100, cyc + 4});
    @(negedge clk);
    A = 32'd3; B = 32'd5;
    wait_done(seen);
    chk("b2b_first_done", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    sb.push_back('{3'b001, cyc + exp_lat(32'd3, 32'd5)});
    start = 1'b0;
    @(negedge clk);
    wait_done(seen);
    chk("b2b_second_done", {31'd0, seen}, 32'd1);
    last_flags = 3'b001;

    // Reset in the middle of a compare aborts it and clears the flags.
    @(negedge clk);
    @(negedge clk);
    A = 32'd5; B = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_cmp", {27'd0, busy, done, Igual, Maior, Menor}, 32'd0);
    sb.delete();
    last_flags = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("after_reset_idle", {27'd0, busy, done, Igual, Maior, Menor}, 32'd0);
    do_cmp(32'd5, 32'd5, 1'b0, 3'b100, 0);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
